// File: rtl/ladybird_inst_queue.sv
`default_nettype none
// ============================================================================
// Module   : ladybird_inst_queue
// Purpose  : Instruction fetch queue between fetch and decode. Buffers
//            {pc, inst} responses in a circular buffer and throttles fetch
//            with credits, because fetch does not honour back-pressure.
//            Discards stale in-flight responses after a flush/redirect.
// Options  : LADYBIRD_IQ_BYPASS_EN - combinational in->out bypass when the
//            queue is empty (0-cycle latency).
// Revision : 1.0 - initial release
// ============================================================================
module ladybird_inst_queue #(
  parameter int XLEN         = 32,
  parameter int DEPTH        = 4,
  parameter int MAX_INFLIGHT = 4
) (
  input  logic            clk,
  input  logic            nrst,
  input  logic            req_fire,
  output logic            fetch_allow,
  input  logic [XLEN-1:0] in_inst,
  input  logic [XLEN-1:0] in_pc,
  input  logic            in_valid,
  input  logic            flush,
  output logic [XLEN-1:0] out_inst,
  output logic [XLEN-1:0] out_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            overflow
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int IW = $clog2(MAX_INFLIGHT + 1);
  localparam int SW = ((CW > IW) ? CW : IW) + 1;

  logic [XLEN-1:0] inst_mem_q [DEPTH];
  logic [XLEN-1:0] pc_mem_q   [DEPTH];

  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [IW-1:0] inflight_q, inflight_d;
  logic [IW-1:0] drop_cnt_q, drop_cnt_d;
  logic          overflow_q, overflow_d;

  logic          w_empty;
  logic          w_accept;   // response is live (not being discarded)
  logic          w_deq_q;    // head of the stored queue is consumed
  logic          w_free;
  logic          w_bypass;
  logic          w_enq;
  logic          w_in_dec;   // response retires one in-flight credit
  logic [SW-1:0] w_occupancy;

  assign w_empty  = (count_q == '0);
  assign w_accept = in_valid & (drop_cnt_q == '0) & ~flush;
  assign w_deq_q  = ~w_empty & ~flush & out_ready;
  assign w_free   = (count_q < CW'(DEPTH)) | w_deq_q;
  assign w_in_dec = in_valid & (inflight_q != '0);

`ifdef LADYBIRD_IQ_BYPASS_EN
  assign w_bypass = w_empty & w_accept;
`else
  assign w_bypass = 1'b0;
`endif

  // A bypassed response taken by decode in the same cycle is never written.
  assign w_enq = w_accept & w_free & ~(w_bypass & out_ready);

  // Output mux: bypass path when enabled and active, otherwise stored head.
  always_comb begin
    out_valid = ~w_empty & ~flush;
    out_inst  = inst_mem_q[rd_ptr_q];
    out_pc    = pc_mem_q[rd_ptr_q];
    if (w_bypass) begin
      out_valid = 1'b1;
      out_inst  = in_inst;
      out_pc    = in_pc;
    end
  end

  // Credit check uses registered state only, so req_fire cannot loop back.
  assign w_occupancy = SW'(count_q) + SW'(inflight_q);
  assign fetch_allow = (w_occupancy < SW'(DEPTH)) &
                       (inflight_q < IW'(MAX_INFLIGHT));
  assign overflow    = overflow_q;

  // Next-state for pointers, occupancy, credits and drop tracking.
  always_comb begin
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    count_d     = count_q;
    inflight_d  = inflight_q;
    drop_cnt_d  = drop_cnt_q;
    overflow_d  = overflow_q | (w_accept & ~w_free);

    if (flush) begin
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      count_d    = '0;
      // Everything still outstanding is stale; a request issued this cycle
      // belongs to the new stream and stays live.
      drop_cnt_d = inflight_q - (w_in_dec ? IW'(1) : IW'(0));
      inflight_d = drop_cnt_d + (req_fire ? IW'(1) : IW'(0));
    end else begin
      if (w_enq)   wr_ptr_d = wr_ptr_q + PW'(1);
      if (w_deq_q) rd_ptr_d = rd_ptr_q + PW'(1);
      case ({w_enq, w_deq_q})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
      case ({req_fire, w_in_dec})
        2'b10:   inflight_d = inflight_q + IW'(1);
        2'b01:   inflight_d = inflight_q - IW'(1);
        default: inflight_d = inflight_q;
      endcase
      if (in_valid && (drop_cnt_q != '0)) drop_cnt_d = drop_cnt_q - IW'(1);
    end
  end

  // Control state registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      inflight_q <= '0;
      drop_cnt_q <= '0;
      overflow_q <= 1'b0;
    end else begin
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      inflight_q <= inflight_d;
      drop_cnt_q <= drop_cnt_d;
      overflow_q <= overflow_d;
    end
  end

  // Entry storage; contents are only meaningful below count, so no reset.
  always_ff @(posedge clk) begin
    if (w_enq && nrst) begin
      inst_mem_q[wr_ptr_q] <= in_inst;
      pc_mem_q[wr_ptr_q]   <= in_pc;
    end
  end

endmodule
`default_nettype wire
